// File: rtl/hmac_arbiter_if.sv
// Command/response bundle between the two HMAC clients, the arbiter and the
// single hmac_core. The arbiter takes the slave side; clients and the core take the master side.
interface hmac_arbiter_if;
  logic [1:0]          cmd_valid;
  logic [1:0]          cmd_ready;
  logic [1:0]          cmd_init;
  logic [1:0]          cmd_last;
  logic [1:0][383:0]   cmd_key;
  logic [1:0][1023:0]  cmd_block;
  logic [1:0]          rsp_valid;
  logic                rsp_err;
  logic [383:0]        rsp_tag;
  logic                lock_timeout;
  logic                core_init;
  logic                core_next;
  logic [383:0]        core_key;
  logic [1023:0]       core_block;
  logic                core_ready;
  logic                core_tag_valid;
  logic [383:0]        core_tag;

  modport slave (
    input  cmd_valid, cmd_init, cmd_last, cmd_key, cmd_block,
    input  core_ready, core_tag_valid, core_tag,
    output cmd_ready, rsp_valid, rsp_err, rsp_tag, lock_timeout,
    output core_init, core_next, core_key, core_block
  );

  modport master (
    output cmd_valid, cmd_init, cmd_last, cmd_key, cmd_block,
    output core_ready, core_tag_valid, core_tag,
    input  cmd_ready, rsp_valid, rsp_err, rsp_tag, lock_timeout,
    input  core_init, core_next, core_key, core_block
  );
endinterface

// File: rtl/hmac_arbiter.sv
// Two-client arbiter/sequencer for the shared HMAC-384 core: locks the core to one
// client per session, holds key/block stable, pulses init/next and routes the tag back.
module hmac_arbiter #(
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  hmac_arbiter_if.slave bus
);

  localparam int CW = (LOCK_TIMEOUT > 255) ? $clog2(LOCK_TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (LOCK_TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            lock_vld;
  logic            lock_id;
  logic            rr_ptr;
  logic            sel;
  logic [383:0]    key_q;
  logic [1023:0]   block_q;
  logic            init_q;
  logic            last_q;
  logic            err_q;
  logic [383:0]    tag_q;
  logic [CW-1:0]   to_cnt;

  logic [1:0]      elig;
  logic            sel_nxt;
  logic            grant;
  logic            owner_idle;
  logic            expire;

  // While locked only the owner may be granted; otherwise round-robin on ties.
  // The timeout fires in the idle cycle that would bring to_cnt up to LOCK_TIMEOUT.
  always_comb begin
    elig = bus.cmd_valid;
    if (lock_vld) begin
      elig = bus.cmd_valid & (lock_id ? 2'b10 : 2'b01);
    end
    sel_nxt    = (elig == 2'b11) ? rr_ptr : elig[1];
    grant      = reset_n && (state == IDLE) && (elig != 2'b00);
    owner_idle = (state == IDLE) && lock_vld && !bus.cmd_valid[lock_id];
    expire     = TO_EN && owner_idle && (to_cnt == TO_LAST);
  end

  assign bus.cmd_ready    = grant ? (sel_nxt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.core_init    = (state == ISSUE) && bus.core_ready && init_q;
  assign bus.core_next    = (state == ISSUE) && bus.core_ready && !init_q;
  assign bus.rsp_valid    = (state == RESP) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_err      = (state == RESP) && err_q;
  assign bus.rsp_tag      = ((state == RESP) && !err_q) ? tag_q : '0;
  assign bus.lock_timeout = expire;
  assign bus.core_key     = key_q;
  assign bus.core_block   = block_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      rr_ptr   <= 1'b0;
      sel      <= 1'b0;
      key_q    <= '0;
      block_q  <= '0;
      init_q   <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      tag_q    <= '0;
      to_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            sel     <= sel_nxt;
            block_q <= bus.cmd_block[sel_nxt];
            init_q  <= bus.cmd_init[sel_nxt];
            last_q  <= bus.cmd_last[sel_nxt];
            tag_q   <= '0;
            to_cnt  <= '0;
            // An init always (re)opens a session, even from the current owner.
            if (bus.cmd_init[sel_nxt]) begin
              key_q    <= bus.cmd_key[sel_nxt];
              lock_vld <= 1'b1;
              lock_id  <= sel_nxt;
              rr_ptr   <= ~sel_nxt;
              state    <= ISSUE;
            end else if (lock_vld) begin
              state <= ISSUE;
            end else begin
              err_q <= 1'b1;
              state <= RESP;
            end
          end else if (!lock_vld) begin
            to_cnt <= '0;
          end else if (expire) begin
            lock_vld <= 1'b0;
            to_cnt   <= '0;
          end else if (owner_idle) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (bus.core_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.core_tag_valid) begin
            tag_q <= bus.core_tag;
            state <= RESP;
          end
        end
        RESP: begin
          if (last_q || err_q) begin
            lock_vld <= 1'b0;
          end
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_arbiter.sv
// Directed bench for hmac_arbiter with a small behavioural stand-in for hmac_core
// (fixed latency, tag = simple keyed mix of key and block).
module tb_hmac_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hmac_arbiter_if bus();

  hmac_arbiter #(.LOCK_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam logic [383:0]  K0 = {12{32'h0123_4567}};
  localparam logic [383:0]  K1 = {12{32'h89AB_CDEF}};
  localparam logic [383:0]  K2 = {12{32'h1357_9BDF}};
  localparam logic [383:0]  K3 = {12{32'h2468_ACE0}};
  localparam logic [383:0]  K4 = {12{32'hDEAD_BEEF}};
  localparam logic [383:0]  K5 = {12{32'h0F1E_2D3C}};
  localparam logic [1023:0] B0 = {32{32'hA5A5_0000}};
  localparam logic [1023:0] B1 = {32{32'h5A5A_1111}};
  localparam logic [1023:0] B2 = {32{32'hC3C3_2222}};
  localparam logic [1023:0] B3 = {32{32'h3C3C_3333}};
  localparam logic [1023:0] B4 = {32{32'h9696_4444}};
  localparam logic [1023:0] B5 = {32{32'h6969_5555}};
  localparam logic [1023:0] B6 = {32{32'h1234_6666}};
  localparam logic [1023:0] B7 = {32{32'hFEDC_7777}};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_init = 0;
  int n_next = 0;

  function automatic logic [383:0] mock_tag(input logic [383:0] k, input logic [1023:0] b);
    return k ^ {k[190:0], k[383:191]} ^ b[383:0] ^ b[767:384] ^ {128'h0, b[1023:768]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.core_init) n_init <= n_init + 1;
    if (bus.core_next) n_next <= n_next + 1;
  end

  // Core stand-in: tag_valid drops on a command and rises three edges after the pulse.
  logic          m_pend;
  logic [1:0]    m_cnt;
  logic [383:0]  m_key;
  logic [1023:0] m_blk;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.core_tag_valid <= 1'b0;
      bus.core_tag       <= '0;
      m_pend <= 1'b0;
      m_cnt  <= 2'd0;
      m_key  <= '0;
      m_blk  <= '0;
    end else if (bus.core_init || bus.core_next) begin
      bus.core_tag_valid <= 1'b0;
      m_pend <= 1'b1;
      m_cnt  <= 2'd2;
      m_blk  <= bus.core_block;
      if (bus.core_init) m_key <= bus.core_key;
    end else if (m_pend) begin
      if (m_cnt == 2'd0) begin
        bus.core_tag_valid <= 1'b1;
        bus.core_tag       <= mock_tag(m_key, m_blk);
        m_pend <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cmd;
    bus.cmd_valid = 2'b00;
    bus.cmd_init  = 2'b00;
    bus.cmd_last  = 2'b00;
  endtask

  task automatic drive_cmd(input int id, input logic init, input logic last,
                           input logic [383:0] key, input logic [1023:0] blk);
    bus.cmd_valid[id] = 1'b1;
    bus.cmd_init[id]  = init;
    bus.cmd_last[id]  = last;
    bus.cmd_key[id]   = key;
    bus.cmd_block[id] = blk;
  endtask

  task automatic wait_rsp(input int id, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid[id]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.cmd_valid = 2'b11;
    bus.cmd_init  = 2'b11;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_cmd_ready: got %b want 00", bus.cmd_ready);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.lock_timeout} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_rsp: got %b want 0000", {bus.rsp_valid, bus.rsp_err, bus.lock_timeout});
    end
    checks++;
    if (bus.rsp_tag !== '0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_tag: got %h want 0", bus.rsp_tag);
    end
    checks++;
    if ({bus.core_init, bus.core_next} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_core_pulse: got %b want 00", {bus.core_init, bus.core_next});
    end
    checks++;
    if (bus.core_key !== '0 || bus.core_block !== '0) begin
      failures++;
      $display("[TB] FAIL reset_core_data: key %h block[127:0] %h want 0", bus.core_key, bus.core_block[127:0]);
    end
    clr_cmd();
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_session;
    bit seen;
    int a_cyc;
    next_cycle();
    drive_cmd(0, 1'b1, 1'b0, K0, B0);
    @(negedge clk);
    a_cyc = cyc;
    checks++;
    if (bus.cmd_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL session_init_grant: cmd_ready %b want 01", bus.cmd_ready);
    end
    next_cycle();
    clr_cmd();
    @(negedge clk);
    checks++;
    if ({bus.core_init, bus.core_next} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL session_init_pulse: init/next %b want 10", {bus.core_init, bus.core_next});
    end
    checks++;
    if (bus.core_key !== K0) begin
      failures++;
      $display("[TB] FAIL session_core_key: got %h want %h", bus.core_key, K0);
    end
    checks++;
    if (bus.core_block !== B0) begin
      failures++;
      $display("[TB] FAIL session_core_block: got[127:0] %h want %h", bus.core_block[127:0], B0[127:0]);
    end
    wait_rsp(0, seen);
    checks++;
    if (!seen || (cyc - a_cyc) != 6) begin
      failures++;
      $display("[TB] FAIL session_init_latency: seen %0d cycles %0d want 6", seen, cyc - a_cyc);
    end
    checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_tag !== mock_tag(K0, B0)) begin
      failures++;
      $display("[TB] FAIL session_init_tag: err %b tag %h want %h", bus.rsp_err, bus.rsp_tag, mock_tag(K0, B0));
    end
    next_cycle();
    drive_cmd(0, 1'b0, 1'b1, K1, B1);
    @(negedge clk);
    a_cyc = cyc;
    checks++;
    if (bus.cmd_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL session_next_grant: cmd_ready %b want 01", bus.cmd_ready);
    end
    next_cycle();
    clr_cmd();
    @(negedge clk);
    checks++;
    if ({bus.core_init, bus.core_next} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL session_next_pulse: init/next %b want 01", {bus.core_init, bus.core_next});
    end
    checks++;
    if (bus.core_key !== K0) begin
      failures++;
      $display("[TB] FAIL session_key_held: got %h want %h", bus.core_key, K0);
    end
    wait_rsp(0, seen);
    checks++;
    if (!seen || (cyc - a_cyc) != 6) begin
      failures++;
      $display("[TB] FAIL session_next_latency: seen %0d cycles %0d want 6", seen, cyc - a_cyc);
    end
    checks++;
    if (bus.rsp_tag !== mock_tag(K0, B1)) begin
      failures++;
      $display("[TB] FAIL session_next_tag: tag %h want %h", bus.rsp_tag, mock_tag(K0, B1));
    end
  endtask

  // Follows straight on from the last response: req1 is granted in the very next cycle.
  task automatic test_error_release;
    int ni;
    int nn;
    ni = n_init;
    nn = n_next;
    next_cycle();
    drive_cmd(1, 1'b0, 1'b0, K1, B2);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL release_then_grant: cmd_ready %b want 10", bus.cmd_ready);
    end
    next_cycle();
    clr_cmd();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL error_rsp: rsp_valid %b err %b want 10 1", bus.rsp_valid, bus.rsp_err);
    end
    checks++;
    if (bus.rsp_tag !== '0) begin
      failures++;
      $display("[TB] FAIL error_tag: got %h want 0", bus.rsp_tag);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL error_rsp_width: rsp_valid %b want 00", bus.rsp_valid);
    end
    repeat (3) next_cycle();
    checks++;
    if (n_init != ni || n_next != nn) begin
      failures++;
      $display("[TB] FAIL error_no_core_op: init %0d next %0d want %0d %0d", n_init, n_next, ni, nn);
    end
  endtask

  task automatic test_both_init;
    bit seen;
    bit bad;
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    drive_cmd(0, 1'b1, 1'b0, K0, B0);
    drive_cmd(1, 1'b1, 1'b1, K1, B2);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL both_init_rr: cmd_ready %b want 01", bus.cmd_ready);
    end
    for (int op = 0; op < 2; op++) begin
      next_cycle();
      bus.cmd_valid[0] = 1'b0;
      seen = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.cmd_ready[1]) bad = 1'b1;
        if (bus.rsp_valid[0]) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen || bad) begin
        failures++;
        $display("[TB] FAIL both_init_lockout op%0d: rsp seen %0d req1 ready seen %0d want 1 0", op, seen, bad);
      end
      if (op == 0) begin
        next_cycle();
        drive_cmd(0, 1'b0, 1'b1, K0, B1);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 2'b01) begin
          failures++;
          $display("[TB] FAIL both_owner_next: cmd_ready %b want 01", bus.cmd_ready);
        end
      end
    end
    checks++;
    if (bus.rsp_tag !== mock_tag(K0, B1)) begin
      failures++;
      $display("[TB] FAIL both_req0_tag: tag %h want %h", bus.rsp_tag, mock_tag(K0, B1));
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL both_req1_grant: cmd_ready %b want 10", bus.cmd_ready);
    end
    next_cycle();
    clr_cmd();
    wait_rsp(1, seen);
    checks++;
    if (!seen || bus.rsp_valid !== 2'b10 || bus.rsp_tag !== mock_tag(K1, B2)) begin
      failures++;
      $display("[TB] FAIL both_req1_tag: seen %0d valid %b tag %h want %h", seen, bus.rsp_valid, bus.rsp_tag, mock_tag(K1, B2));
    end
  endtask

  // LOCK_TIMEOUT = 4: pulse in the 4th idle cycle after the response, req1 granted next.
  task automatic test_timeout;
    bit seen;
    logic [3:0] lt_bits;
    bit rdy_any;
    next_cycle();
    drive_cmd(0, 1'b1, 1'b0, K2, B3);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 2'b01) begin
      failures++;
      $display("[TB] FAIL timeout_init_grant: cmd_ready %b want 01", bus.cmd_ready);
    end
    next_cycle();
    clr_cmd();
    drive_cmd(1, 1'b1, 1'b1, K3, B4);
    wait_rsp(0, seen);
    lt_bits = 4'b0000;
    rdy_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      lt_bits[i] = bus.lock_timeout;
      if (bus.cmd_ready != 2'b00) rdy_any = 1'b1;
    end
    checks++;
    if (!seen || lt_bits !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL timeout_pulse: rsp %0d pulses %b want 1000", seen, lt_bits);
    end
    checks++;
    if (rdy_any) begin
      failures++;
      $display("[TB] FAIL timeout_hold: cmd_ready seen %0d want 0", rdy_any);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 2'b10 || bus.lock_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_grant: cmd_ready %b lock_timeout %b want 10 0", bus.cmd_ready, bus.lock_timeout);
    end
    next_cycle();
    clr_cmd();
    wait_rsp(1, seen);
    checks++;
    if (!seen || bus.rsp_tag !== mock_tag(K3, B4)) begin
      failures++;
      $display("[TB] FAIL timeout_req1_tag: seen %0d tag %h want %h", seen, bus.rsp_tag, mock_tag(K3, B4));
    end
  endtask

  task automatic test_timeout_race;
    bit seen;
    next_cycle();
    drive_cmd(0, 1'b1, 1'b0, K2, B5);
    next_cycle();
    clr_cmd();
    wait_rsp(0, seen);
    repeat (3) next_cycle();
    next_cycle();
    drive_cmd(0, 1'b0, 1'b1, K2, B6);
    @(negedge clk);
    checks++;
    if (!seen || bus.cmd_ready !== 2'b01 || bus.lock_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL race_cmd_wins: rsp %0d cmd_ready %b lock_timeout %b want 01 0", seen, bus.cmd_ready, bus.lock_timeout);
    end
    next_cycle();
    clr_cmd();
    wait_rsp(0, seen);
    checks++;
    if (!seen || bus.rsp_tag !== mock_tag(K2, B6)) begin
      failures++;
      $display("[TB] FAIL race_tag: seen %0d tag %h want %h", seen, bus.rsp_tag, mock_tag(K2, B6));
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    bit rsp_bad;
    next_cycle();
    drive_cmd(1, 1'b1, 1'b1, K3, B5);
    next_cycle();
    clr_cmd();
    next_cycle();
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.core_key !== '0 || bus.core_block !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_core_data: key %h block[127:0] %h want 0", bus.core_key, bus.core_block[127:0]);
    end
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.lock_timeout, bus.core_init, bus.core_next} !== 8'h00 ||
        bus.rsp_tag !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: ctl %b tag %h want 0",
               {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.lock_timeout, bus.core_init, bus.core_next}, bus.rsp_tag);
    end
    rsp_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) rsp_bad = 1'b1;
    end
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    drive_cmd(1, 1'b1, 1'b1, K4, B6);
    @(negedge clk);
    checks++;
    if (rsp_bad || bus.cmd_ready !== 2'b10) begin
      failures++;
      $display("[TB] FAIL midreset_regrant: stray rsp %0d cmd_ready %b want 0 10", rsp_bad, bus.cmd_ready);
    end
    next_cycle();
    clr_cmd();
    wait_rsp(1, seen);
    checks++;
    if (!seen || bus.rsp_err !== 1'b0 || bus.rsp_tag !== mock_tag(K4, B6)) begin
      failures++;
      $display("[TB] FAIL midreset_tag: seen %0d err %b tag %h want %h", seen, bus.rsp_err, bus.rsp_tag, mock_tag(K4, B6));
    end
  endtask

  task automatic test_core_stall;
    bit seen;
    bit pulse_seen;
    bit blk_bad;
    int ni;
    ni = n_init;
    next_cycle();
    bus.core_ready = 1'b0;
    drive_cmd(0, 1'b1, 1'b1, K5, B7);
    next_cycle();
    clr_cmd();
    pulse_seen = 1'b0;
    blk_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.core_init || bus.core_next) pulse_seen = 1'b1;
      if (bus.core_block !== B7) blk_bad = 1'b1;
      next_cycle();
    end
    bus.core_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (pulse_seen || bus.core_init !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_pulse: early %0d core_init %b want 0 1", pulse_seen, bus.core_init);
    end
    wait_rsp(0, seen);
    if (bus.core_block !== B7) blk_bad = 1'b1;
    checks++;
    if (blk_bad) begin
      failures++;
      $display("[TB] FAIL stall_block_stable: changed %0d want 0", blk_bad);
    end
    checks++;
    if (n_init - ni != 1) begin
      failures++;
      $display("[TB] FAIL stall_pulse_count: got %0d want 1", n_init - ni);
    end
    checks++;
    if (!seen || bus.rsp_tag !== mock_tag(K5, B7)) begin
      failures++;
      $display("[TB] FAIL stall_tag: seen %0d tag %h want %h", seen, bus.rsp_tag, mock_tag(K5, B7));
    end
  endtask

  initial begin
    bus.cmd_valid  = 2'b00;
    bus.cmd_init   = 2'b00;
    bus.cmd_last   = 2'b00;
    bus.cmd_key    = '0;
    bus.cmd_block  = '0;
    bus.core_ready = 1'b1;
    test_reset();
    test_session();
    test_error_release();
    test_both_init();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_core_stall();
    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
